// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer running on the always-present reference clock.
// Pulses the PLL reset, qualifies lock, releases the downstream reset and retries on lock loss.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 4,
  parameter int CNT_W               = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       pll_ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    ASSERT_RST = 3'd0,
    WAIT_LOCK  = 3'd1,
    QUALIFY    = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

  logic             lk_m, lk_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic             attempt_failed;

  // pll_locked is asynchronous to refclk; every decision below uses lk_s only.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lk_m <= 1'b0;
      lk_s <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the pre-edge values, forming a real 2-stage chain.
      lk_m <= pll_locked;
      lk_s <= lk_m;
    end
  end

  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign retry_inc = (retry_q >= RETRY_MAX) ? RETRY_MAX : retry_q + 4'd1;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d        = state_q;
    cnt_d          = cnt_q;
    retry_d        = retry_q;
    attempt_failed = 1'b0;

    if (relock_req) begin
      state_d = ASSERT_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ASSERT_RST: begin
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        WAIT_LOCK: begin
          if (lk_s) begin
            state_d = QUALIFY;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            attempt_failed = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        QUALIFY: begin
          // A dropout is a glitch, not a failed attempt, but the timeout window restarts.
          if (!lk_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RUN: begin
          if (!lk_s) attempt_failed = 1'b1;
        end
        FAULT: ;
        default: begin
          state_d = ASSERT_RST;
          cnt_d   = '0;
        end
      endcase

      if (attempt_failed) begin
        retry_d = retry_inc;
        cnt_d   = '0;
        state_d = (retry_inc == RETRY_MAX) ? FAULT : ASSERT_RST;
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ASSERT_RST;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  // Outputs are registered from the next state so they change with the state, glitch-free.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      pll_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      pll_rst   <= (state_d == ASSERT_RST) || (state_d == FAULT);
      sys_rst_n <= (state_d == RUN);
      pll_ready <= (state_d == RUN);
      fault     <= (state_d == FAULT);
    end
  end

  assign retry_cnt = retry_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed vector table, hand-written
// glitch/async-reset sequences, then random lock activity against a behavioural model.
module tb_pll_reset_sequencer;

  localparam int RST_P  = 16;
  localparam int TO_P   = 100;
  localparam int STB_P  = 8;
  localparam int MAXR_P = 3;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst, sys_rst_n, pll_ready, fault;
  logic [3:0] retry_cnt;
  logic [2:0] state_o;

  int checks   = 0;
  int failures = 0;

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(RST_P), .LOCK_TIMEOUT_CYCLES(TO_P), .LOCK_STABLE_CYCLES(STB_P),
    .MAX_RETRIES(MAXR_P), .CNT_W(8)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .pll_ready(pll_ready), .fault(fault),
    .retry_cnt(retry_cnt), .state_o(state_o)
  );

  always #5 refclk = ~refclk;

  // {state_o, retry_cnt, pll_rst, sys_rst_n, pll_ready, fault}
  logic [10:0] dut_out;
  assign dut_out = {state_o, retry_cnt, pll_rst, sys_rst_n, pll_ready, fault};

  function automatic logic [10:0] pack_out(int st, int rc, bit pr, bit sr, bit rd, bit ft);
    return {3'(st), 4'(rc), pr, sr, rd, ft};
  endfunction

  localparam logic [10:0] RESET_VEC = 11'b000_0000_1000;

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {st,rc,prst,srst_n,rdy,flt}=%b_%b_%b required %b_%b_%b at %0t",
               name, got[10:8], got[7:4], got[3:0], exp[10:8], exp[7:4], exp[3:0], $time);
    end
  endtask

  task automatic run(input int n, input logic lk, input logic req, input logic [10:0] exp,
                     input string name);
    pll_locked = lk;
    relock_req = req;
    repeat (n) @(negedge refclk);
    check(name, dut_out, exp);
  endtask

  // ---------------- behavioural reference model ----------------
  // Phases follow the published state_o encoding; "elapsed" counts whole cycles spent in
  // the current window, and lock is seen through a two-cycle delay line.
  typedef struct packed {
    int       phase;
    int       elapsed;
    int       retries;
    logic [1:0] dly;
  } model_t;

  model_t mdl;

  function automatic model_t model_step(model_t m, logic lk, logic req);
    model_t n = m;
    logic   seen = m.dly[1];
    bit     failed = 1'b0;
    n.dly = {m.dly[0], lk};
    if (req) begin
      n.phase = 0; n.elapsed = 0; n.retries = 0;
    end else begin
      case (m.phase)
        0: begin
          n.elapsed = m.elapsed + 1;
          if (n.elapsed == RST_P) begin n.phase = 1; n.elapsed = 0; end
        end
        1: begin
          if (seen) begin n.phase = 2; n.elapsed = 0; end
          else begin
            n.elapsed = m.elapsed + 1;
            if (n.elapsed == TO_P) failed = 1'b1;
          end
        end
        2: begin
          if (!seen) begin n.phase = 1; n.elapsed = 0; end
          else begin
            n.elapsed = m.elapsed + 1;
            if (n.elapsed == STB_P) begin n.phase = 3; n.elapsed = 0; end
          end
        end
        3: if (!seen) failed = 1'b1;
        default: ;
      endcase
      if (failed) begin
        n.retries = (m.retries + 1 > MAXR_P) ? MAXR_P : m.retries + 1;
        n.phase   = (n.retries == MAXR_P) ? 4 : 0;
        n.elapsed = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [10:0] model_out(model_t m);
    return pack_out(m.phase, m.retries, (m.phase == 0) || (m.phase == 4),
                    m.phase == 3, m.phase == 3, m.phase == 4);
  endfunction

  always @(posedge refclk or negedge rst_n) begin
    if (!rst_n) mdl <= '0;
    else        mdl <= model_step(mdl, pll_locked, relock_req);
  end

  // ---------------- directed vector table ----------------
  typedef struct packed {
    int          hold;
    logic        lk;
    logic        req;
    logic [10:0] exp;
  } vec_t;

  function automatic vec_t mk(int hold, bit lk, bit req, int st, int rc, bit pr, bit sr, bit rd, bit ft);
    vec_t v;
    v.hold = hold; v.lk = lk; v.req = req;
    v.exp  = pack_out(st, rc, pr, sr, rd, ft);
    return v;
  endfunction

  vec_t tbl[38];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset release, 16-cycle pulse, lock 40 cycles later, qualify, run
    tbl[0]  = mk(15, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[1]  = mk(1,  0, 0, 1, 0, 0, 0, 0, 0);
    tbl[2]  = mk(40, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[3]  = mk(2,  1, 0, 1, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1,  1, 0, 2, 0, 0, 0, 0, 0);
    tbl[5]  = mk(7,  1, 0, 2, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1,  1, 0, 3, 0, 0, 1, 1, 0);
    tbl[7]  = mk(20, 1, 0, 3, 0, 0, 1, 1, 0);
    // one-cycle lock drop in RUN: falls 3 cycles later, then reacquire
    tbl[8]  = mk(1,  0, 0, 3, 0, 0, 1, 1, 0);
    tbl[9]  = mk(1,  1, 0, 3, 0, 0, 1, 1, 0);
    tbl[10] = mk(1,  1, 0, 0, 1, 1, 0, 0, 0);
    tbl[11] = mk(15, 1, 0, 0, 1, 1, 0, 0, 0);
    tbl[12] = mk(1,  1, 0, 1, 1, 0, 0, 0, 0);
    tbl[13] = mk(1,  1, 0, 2, 1, 0, 0, 0, 0);
    tbl[14] = mk(7,  1, 0, 2, 1, 0, 0, 0, 0);
    tbl[15] = mk(1,  1, 0, 3, 1, 0, 1, 1, 0);
    // relock_req held several cycles keeps restarting the pulse
    tbl[16] = mk(5,  1, 1, 0, 0, 1, 0, 0, 0);
    tbl[17] = mk(15, 1, 0, 0, 0, 1, 0, 0, 0);
    tbl[18] = mk(1,  1, 0, 1, 0, 0, 0, 0, 0);
    // lock never comes: three timeouts then FAULT
    tbl[19] = mk(1,  0, 1, 0, 0, 1, 0, 0, 0);
    tbl[20] = mk(16, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[21] = mk(99, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[22] = mk(1,  0, 0, 0, 1, 1, 0, 0, 0);
    tbl[23] = mk(16, 0, 0, 1, 1, 0, 0, 0, 0);
    tbl[24] = mk(100,0, 0, 0, 2, 1, 0, 0, 0);
    tbl[25] = mk(16, 0, 0, 1, 2, 0, 0, 0, 0);
    tbl[26] = mk(99, 0, 0, 1, 2, 0, 0, 0, 0);
    tbl[27] = mk(1,  0, 0, 4, 3, 1, 0, 0, 1);
    tbl[28] = mk(50, 0, 0, 4, 3, 1, 0, 0, 1);
    // relock from FAULT, full sequence completes
    tbl[29] = mk(1,  1, 1, 0, 0, 1, 0, 0, 0);
    tbl[30] = mk(16, 1, 0, 1, 0, 0, 0, 0, 0);
    tbl[31] = mk(1,  1, 0, 2, 0, 0, 0, 0, 0);
    tbl[32] = mk(8,  1, 0, 3, 0, 0, 1, 1, 0);
    // relock_req on the exact timeout cycle wins: retry_cnt stays 0
    tbl[33] = mk(1,  0, 1, 0, 0, 1, 0, 0, 0);
    tbl[34] = mk(16, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[35] = mk(99, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[36] = mk(1,  0, 1, 0, 0, 1, 0, 0, 0);
    tbl[37] = mk(16, 0, 0, 1, 0, 0, 0, 0, 0);

    rst_n      = 1'b0;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    repeat (3) @(negedge refclk);
    check("reset_values", dut_out, RESET_VEC);
    rst_n = 1'b1;

    for (int i = 0; i < 38; i++)
      run(tbl[i].hold, tbl[i].lk, tbl[i].req, tbl[i].exp, $sformatf("vec%0d", i));

    // QUALIFY glitch at count 5: back to WAIT_LOCK, then 8 fresh cycles
    run(2, 1, 0, pack_out(1, 0, 0, 0, 0, 0), "glitch_wait");
    run(1, 1, 0, pack_out(2, 0, 0, 0, 0, 0), "glitch_qualify_entry");
    run(3, 1, 0, pack_out(2, 0, 0, 0, 0, 0), "glitch_qualify_cnt3");
    run(1, 0, 0, pack_out(2, 0, 0, 0, 0, 0), "glitch_low_in");
    run(1, 1, 0, pack_out(2, 0, 0, 0, 0, 0), "glitch_cnt5");
    run(1, 1, 0, pack_out(1, 0, 0, 0, 0, 0), "glitch_back_to_wait");
    run(1, 1, 0, pack_out(2, 0, 0, 0, 0, 0), "glitch_requalify");
    run(7, 1, 0, pack_out(2, 0, 0, 0, 0, 0), "glitch_not_yet_run");
    run(1, 1, 0, pack_out(3, 0, 0, 1, 1, 0), "glitch_release");

    // asynchronous reset mid-QUALIFY and mid-RUN
    run(1, 1, 1, pack_out(0, 0, 1, 0, 0, 0), "async_prep_relock");
    run(16, 1, 0, pack_out(1, 0, 0, 0, 0, 0), "async_prep_wait");
    run(4, 1, 0, pack_out(2, 0, 0, 0, 0, 0), "async_mid_qualify");
    #3 rst_n = 1'b0;
    #1 check("async_rst_in_qualify", dut_out, RESET_VEC);
    @(negedge refclk);
    rst_n = 1'b1;
    run(16, 1, 0, pack_out(1, 0, 0, 0, 0, 0), "async_after_q_wait");
    run(1, 1, 0, pack_out(2, 0, 0, 0, 0, 0), "async_after_q_qualify");
    run(8, 1, 0, pack_out(3, 0, 0, 1, 1, 0), "async_mid_run");
    #3 rst_n = 1'b0;
    #1 check("async_rst_in_run", dut_out, RESET_VEC);
    @(negedge refclk);
    rst_n = 1'b1;

    // random lock activity against the reference model
    begin
      int   f0  = failures;
      int   seg = 0;
      logic lk_val = 1'b0;
      for (int c = 0; c < 4000 && (failures - f0) < 20; c++) begin
        if (seg == 0) begin
          seg    = $urandom_range(1, 120);
          lk_val = ($urandom_range(0, 3) != 0);
        end
        seg--;
        pll_locked = lk_val;
        relock_req = ($urandom_range(0, 149) == 0);
        @(negedge refclk);
        check("random_vs_model", dut_out, model_out(mdl));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
